// File: rtl/hidden_cpu_sequencer.sv
// Program-buffer instruction sequencer for the HiddenCPU core: loads words, then replays them
// one per clock with optional looping or single-stepping.
module hidden_cpu_sequencer #(
  parameter int              DEPTH    = 16,
  parameter int              AW       = 4,
  parameter int              IW       = 6,
  parameter int              LW       = 4,
  parameter logic [IW-1:0]   NOP_WORD = 6'b000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [LW-1:0] loops,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  output logic [AW-1:0] issue_addr,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  state_t        state, nextState;
  logic [IW-1:0] progBuf [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [LW-1:0] loopLeft;
  logic          full, lastAddr;
  logic          issue, wrEn, ovfSet, startAccept;

  assign full     = (count == FULL_COUNT);
  assign lastAddr = ({1'b0, rdPtr} == (count - ONE_COUNT));

  always_comb begin
    nextState   = state;
    issue       = 1'b0;
    wrEn        = 1'b0;
    ovfSet      = 1'b0;
    startAccept = 1'b0;
    unique case (state)
      IDLE: begin
        // start takes the cycle even when refused, so a coincident load is always dropped
        if (start) begin
          if (count != '0) begin
            startAccept = 1'b1;
            nextState   = RUN;
          end
        end else if (load_valid) begin
          if (full) ovfSet = 1'b1;
          else      wrEn   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          nextState = IDLE;
        end else if (!step_mode || step) begin
          issue = 1'b1;
          if (lastAddr && loopLeft == '0) nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (rst || clear) begin
      nextState   = IDLE;
      issue       = 1'b0;
      wrEn        = 1'b0;
      ovfSet      = 1'b0;
      startAccept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) progBuf[wrPtr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      loopLeft    <= '0;
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      issue_addr  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= nextState;
      busy        <= (nextState == RUN);
      done        <= (state == DONE) && !clear;
      instr_valid <= issue;
      instr_out   <= issue ? progBuf[rdPtr] : NOP_WORD;
      if (issue) issue_addr <= rdPtr;

      if (clear) begin
        count    <= '0;
        wrPtr    <= '0;
        rdPtr    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wrEn) begin
          wrPtr <= wrPtr + AW'(1);
          count <= count + ONE_COUNT;
        end
        if (ovfSet) overflow <= 1'b1;
        if (startAccept) begin
          rdPtr    <= '0;
          loopLeft <= loops;
        end
        if (issue) begin
          if (lastAddr) begin
            rdPtr <= '0;
            if (loopLeft != '0) loopLeft <= loopLeft - LW'(1);
          end else begin
            rdPtr <= rdPtr + AW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/hidden_cpu_sequencer.md
Name: hidden_cpu_sequencer

Overview:
Instruction sequencer that drives the 6-bit instruction field (opcode[5:4], addrs[3:0]) of the HiddenCPU core from a small on-chip program buffer. Programs are loaded one word per cycle, then replayed at one instruction per clock, optionally looped N times or single-stepped. Sits between the chip's input pins and the core's instruction inputs; it replaces direct pin-driven instruction issue.

Parameters:
DEPTH, 16, program buffer entries (power of two)
AW, 4, buffer address width, log2(DEPTH)
IW, 6, instruction width
LW, 4, loop-count width
NOP_WORD, 6'b000000, word driven on instr_out whenever no instruction issues

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clear  input  1  empty buffer and return to IDLE
load_valid  input  1  write load_data into buffer this cycle
load_data  input  IW  program word
start  input  1  begin replay (pulse)
loops  input  LW  extra passes after the first; sampled on accepted start
step_mode  input  1  1 = issue only on step pulses
step  input  1  single-step issue request
abort  input  1  stop replay, go to IDLE
instr_out  output  IW  instruction to core
instr_valid  output  1  instr_out is a real issued instruction
issue_addr  output  AW  buffer index of current instr_out
count  output  AW+1  words loaded (0..DEPTH)
busy  output  1  state is RUN
done  output  1  one-cycle pulse when replay completes
overflow  output  1  sticky: load attempted while full

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, count=0, wr_ptr=0, rd_ptr=0, loop_left=0, instr_out=NOP_WORD, instr_valid=0, issue_addr=0, busy=0, done=0, overflow=0. Buffer contents need not be cleared. Reset mid-RUN abandons the replay immediately, with no done pulse.
- All outputs registered; one cycle from the deciding edge to the output.
- States: IDLE, RUN, DONE.
- IDLE: load_valid with count<DEPTH -> buf[wr_ptr]<=load_data, wr_ptr++, count++. load_valid with count==DEPTH -> write dropped, overflow<=1. start with count>0 -> RUN, rd_ptr<=0, loop_left<=loops. start with count==0 -> ignored, stay IDLE. start and load_valid in the same cycle -> load is dropped (no write, no overflow), start is evaluated against the pre-cycle count.
- RUN: issue condition = step_mode==0, or step==1. On issue: instr_out<=buf[rd_ptr], issue_addr<=rd_ptr, instr_valid<=1. Without issue: instr_out<=NOP_WORD, instr_valid<=0. load_valid and start are ignored in RUN.
- End of pass, i.e. an issue with rd_ptr==count-1: if loop_left>0, then loop_left--, rd_ptr<=0, stay RUN. Otherwise go to DONE.
- Otherwise an issue sets rd_ptr++.
- Total issued instructions = count*(loops+1). Back-to-back with no bubble at pass wrap.
- DONE: lasts one cycle. done=1, instr_valid=0, then IDLE. The buffer is retained, so start can replay it.
- abort in RUN: next state IDLE, no issue that cycle, no done. abort in IDLE or DONE has no effect.
- clear in any state has highest priority after rst: count=0, wr_ptr=0, rd_ptr=0, overflow=0, state IDLE, instr_valid=0.
- Priority: rst > clear > abort > start/load > issue.
- step is level-sampled each clock. Holding step high issues one instruction per cycle.
- Pointer arithmetic is modulo DEPTH. count saturates at DEPTH and never wraps.
- busy=1 exactly in RUN.

Test Plan:
- Load 3 words 0x11, 0x22, 0x33; start with loops=0 -> instr_valid high for exactly 3 consecutive cycles beginning 1 cycle after start; instr_out 0x11, 0x22, 0x33; issue_addr 0, 1, 2; done pulses the following cycle; busy then 0.
- Same program, loops=2 -> 9 consecutive issues repeating 0x11, 0x22, 0x33 with no gap at wraps; single done pulse.
- Load 17 words with DEPTH=16 -> count=16, overflow=1, the 17th word never issues; clear -> count=0, overflow=0.
- start with count=0 -> state stays IDLE, instr_valid=0, no done pulse; start and load_valid in the same cycle on a 2-word buffer -> count stays 2, replay issues 2 words.
- step_mode=1, 2-word program, step pulses 5 cycles apart -> each pulse yields exactly one issue; NOP_WORD with instr_valid=0 between pulses; done after 2nd pulse.
- rst asserted at the 2nd issue of a 4-word run -> next cycle all outputs at reset values, count=0, no done pulse; abort mid-run (separate run) -> IDLE, buffer retained, restart replays from 0.
